// File: rtl/button_pkg.sv
// button_pkg: shared FSM state encoding and counter sizing for button event logic.
package button_pkg;
    typedef enum logic [1:0] {IDLE, DOWN, HELD} state_t;
    function automatic int cnt_width(int a, int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop synchronizer for an asynchronous single-bit level.
module sync_ff #(
    parameter int Stages = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [Stages-1:0] ff;
    always_ff @(posedge clock) begin
        if (!reset_n) ff <= '0;
        else ff <= (ff << 1) | Stages'(d);
    end
    assign q = ff[Stages-1];
endmodule

// File: rtl/button_events.sv
// button_events: turns a debounced button level into press, release, long-press and auto-repeat pulses.
module button_events
    import button_pkg::*;
#(
    parameter int LongPress    = 1000,
    parameter int RepeatPeriod = 250,
    parameter bit Inverted     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sigin,
    output logic held,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);
    localparam int CntW = cnt_width(LongPress, RepeatPeriod);
    localparam logic [CntW-1:0] LongM1 = CntW'(LongPress - 1);
    localparam logic [CntW-1:0] RepM1 = RepeatPeriod > 0 ? CntW'(RepeatPeriod - 1) : '0;
    if (LongPress < 2) begin : g_bad_long_press
        $error("button_events: LongPress must be at least 2");
    end
    state_t state;
    logic [CntW-1:0] cnt;
    logic lvl;
    sync_ff #(.Stages(2)) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (sigin ^ Inverted),
        .q      (lvl)
    );
    // A low level always wins, so a pulse due in the release cycle is dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            held          <= lvl;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: if (lvl) begin
                    press <= 1'b1;
                    cnt   <= LongM1;
                    state <= DOWN;
                end
                DOWN: if (!lvl) begin
                    release_pulse <= 1'b1;
                    state         <= IDLE;
                end else if (cnt == '0) begin
                    long_press <= 1'b1;
                    cnt        <= RepM1;
                    state      <= HELD;
                end else cnt <= cnt - 1'b1;
                HELD: if (!lvl) begin
                    release_pulse <= 1'b1;
                    state         <= IDLE;
                end else if (RepeatPeriod > 0) begin
                    repeat_pulse <= cnt == '0;
                    cnt          <= cnt == '0 ? RepM1 : cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed checks of pulse timing on three configurations
// (normal, repeat disabled, inverted input), all with LongPress=8.
module tb_button_events;
    localparam int P = 3, R = 2, L = 1, Q = 0;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] sig = 3'b100;
    logic [2:0] hl, pr, rl, lp, rp;
    logic [3:0] ev [3];
    int cyc = 0, total = 0, bad = 0, k = 0;
    int n [3][4], f [3][4], l [3][4];
    int multi = 0, rst_hi = 0, c_any = 0, ha = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    button_events #(.LongPress(8), .RepeatPeriod(4), .Inverted(1'b0)) u_a (
        .clock(clock), .reset_n(reset_n), .sigin(sig[0]), .held(hl[0]), .press(pr[0]),
        .release_pulse(rl[0]), .long_press(lp[0]), .repeat_pulse(rp[0]));
    button_events #(.LongPress(8), .RepeatPeriod(0), .Inverted(1'b0)) u_b (
        .clock(clock), .reset_n(reset_n), .sigin(sig[1]), .held(hl[1]), .press(pr[1]),
        .release_pulse(rl[1]), .long_press(lp[1]), .repeat_pulse(rp[1]));
    button_events #(.LongPress(8), .RepeatPeriod(4), .Inverted(1'b1)) u_c (
        .clock(clock), .reset_n(reset_n), .sigin(sig[2]), .held(hl[2]), .press(pr[2]),
        .release_pulse(rl[2]), .long_press(lp[2]), .repeat_pulse(rp[2]));

    for (genvar i = 0; i < 3; i++) begin : g_ev
        assign ev[i] = {pr[i], rl[i], lp[i], rp[i]};
    end

    // Event log: count, first and last edge number of each pulse type per instance.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (ev[i][j]) begin
                    if (n[i][j] == 0) f[i][j] = cyc;
                    l[i][j] = cyc;
                    n[i][j]++;
                end
            end
            if ($countones(ev[i]) > 1) multi++;
            if (!reset_n && (ev[i] != 4'd0 || hl[i])) rst_hi++;
        end
        if (ev[2] != 4'd0) c_any++;
        if (hl[0]) ha++;
    end

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_n(int c);
        repeat (c) @(negedge clock);
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) begin
                n[i][j] = 0;
                f[i][j] = -1;
                l[i][j] = -1;
            end
        ha = 0;
    endtask

    task automatic hit(int idx);
        @(negedge clock);
        sig[idx] = ~sig[idx];
        k = cyc;
    endtask

    initial begin
        clr();
        sig = 3'b101;
        wait_n(5);
        reset_n = 1'b1;
        k = cyc;
        chk("reset_quiet", rst_hi, 0);
        chk("reset_no_press", n[0][P], 0);
        wait_n(4);
        chk("reset_press_t", f[0][P], k + 3);
        chk("reset_held", int'(hl[0]), 1);
        sig[0] = 1'b0;
        wait_n(10);
        clr();

        hit(0); wait_n(5); sig[0] = 1'b0; wait_n(8);
        chk("short_press_n", n[0][P], 1);
        chk("short_press_t", f[0][P], k + 3);
        chk("short_rel_t", f[0][R], k + 8);
        chk("short_long_n", n[0][L], 0);
        chk("short_held_n", ha, 5);
        clr();

        hit(0); wait_n(30); sig[0] = 1'b0; wait_n(10);
        chk("long_press_t", f[0][P], k + 3);
        chk("long_long_t", f[0][L], k + 11);
        chk("long_long_n", n[0][L], 1);
        chk("long_rep_n", n[0][Q], 5);
        chk("long_rep_first", f[0][Q], k + 15);
        chk("long_rep_last", l[0][Q], k + 31);
        chk("long_rel_t", f[0][R], k + 33);
        chk("long_rel_n", n[0][R], 1);
        clr();

        hit(0); wait_n(8); sig[0] = 1'b0; wait_n(8);
        chk("coin_press_t", f[0][P], k + 3);
        chk("coin_rel_t", f[0][R], k + 11);
        chk("coin_long_n", n[0][L], 0);
        clr();

        hit(1); wait_n(40); sig[1] = 1'b0; wait_n(8);
        chk("norep_press_t", f[1][P], k + 3);
        chk("norep_long_t", f[1][L], k + 11);
        chk("norep_rep_n", n[1][Q], 0);
        chk("norep_rel_t", f[1][R], k + 43);
        chk("inv_idle_quiet", c_any, 0);
        clr();

        hit(2); wait_n(12); sig[2] = 1'b1; wait_n(8);
        chk("inv_press_t", f[2][P], k + 3);
        chk("inv_long_t", f[2][L], k + 11);
        chk("inv_rel_t", f[2][R], k + 15);
        chk("inv_rep_n", n[2][Q], 0);
        clr();

        hit(0); wait_n(6); reset_n = 1'b0; sig[0] = 1'b0; wait_n(3); reset_n = 1'b1; wait_n(8);
        chk("midrst_press_n", n[0][P], 1);
        chk("midrst_rel_n", n[0][R], 0);
        clr();

        hit(0); wait_n(1); sig[0] = 1'b0; wait_n(6);
        chk("pulse_press_t", f[0][P], k + 3);
        chk("pulse_rel_t", f[0][R], k + 4);
        chk("one_hot_pulses", multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter LongPress, default 1000, meaning the cycles from press pulse to long_press pulse; legal range is at least 2.
REQ-002 SHALL have parameter RepeatPeriod, default 250, meaning the cycles between repeat pulses; 0 disables repeat.
REQ-003 SHALL have parameter Inverted, default 0, meaning that when set, sigin is active-low (low = button down).
REQ-004 SHALL have port clock, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, width 1: reset, synchronous and active-low.
REQ-006 SHALL have port sigin, input, width 1: debounced button level, asynchronous to clock.
REQ-007 SHALL have port held, output, width 1: registered synchronized button-down level.
REQ-008 SHALL have port press, output, width 1: one-cycle pulse on button-down.
REQ-009 SHALL have port release, output, width 1: one-cycle pulse on button-up.
REQ-010 SHALL have port long_press, output, width 1: one-cycle pulse after LongPress cycles held.
REQ-011 SHALL have port repeat, output, width 1: one-cycle pulse every RepeatPeriod cycles after long_press while held.

Function
REQ-012 SHALL pass sigin (XOR Inverted) through a 2-flop synchronizer; the second flop output is "lvl".
REQ-013 SHALL run an FSM with states IDLE, DOWN and HELD, plus a down-counter "cnt".
REQ-014 SHALL, in IDLE with lvl=1: pulse press next cycle, load cnt=LongPress-1, go to DOWN.
REQ-015 SHALL make sigin-to-press latency exactly 3 rising edges (2 synchronizer + 1 output register).
REQ-016 SHALL, in DOWN with lvl=1: decrement cnt; at cnt=0, pulse long_press, load cnt=RepeatPeriod-1 and go to HELD.
REQ-017 SHALL, in HELD with lvl=1 and RepeatPeriod>0: decrement cnt; at cnt=0, pulse repeat and reload RepeatPeriod-1.
REQ-018 SHALL, in HELD with RepeatPeriod=0: hold cnt and never assert repeat.
REQ-019 SHALL, in DOWN or HELD with lvl=0: pulse release next cycle, go to IDLE, and suppress any long_press or repeat due that cycle.
REQ-020 SHALL make held equal lvl delayed by one register, aligned with press and release.
REQ-021 SHALL never assert more than one of press, release, long_press or repeat in a cycle, and each SHALL last exactly one cycle.
REQ-022 SHALL size cnt at $clog2(max(LongPress,RepeatPeriod)+1) bits; there is no wrap, since a reload always happens at 0.
REQ-023 SHALL produce press then release, in consecutive pulses, for a lvl high of 1 cycle.

Reset
REQ-024 SHALL, while reset_n=0 at a clock edge: clear both synchronizer flops, set state=IDLE and cnt=0, and drive all outputs 0.
REQ-025 SHALL, on reset mid-press, produce no release pulse.
REQ-026 SHALL, if lvl=1 after reset release, produce a fresh press pulse per REQ-014.

Structure
REQ-027 SHALL take the state enum (IDLE/DOWN/HELD) and the count-width function from shared package button_pkg.
REQ-028 SHALL implement the synchronizer as sub-module sync_ff (parameter Stages=2, with clock and reset_n), reused codebase-wide.
REQ-029 SHALL flag LongPress<2 with an elaboration-time error.

Verification (LongPress=8, RepeatPeriod=4, Inverted=0)
REQ-030 Reset: hold reset_n=0 with sigin=1 for 5 cycles -> all outputs 0 throughout; press appears 3 edges after reset_n=1.
REQ-031 Short press: sigin high 5 cycles -> press at edge 3 after rise, release at edge 3 after fall, no long_press, held high 5 cycles.
REQ-032 Long and repeat: sigin high 30 cycles -> press at t; long_press at t+8; repeat at t+12, t+16, t+20, t+24, t+28, t+32 if still held; then release.
REQ-033 Coincidence: release lvl in the exact cycle long_press is due -> release only, no long_press.
REQ-034 Disabled repeat: RepeatPeriod=0, sigin high 40 cycles -> press and long_press only, then release.
REQ-035 Inverted=1: sigin low 12 cycles -> press, then long_press 8 cycles later, then release; the idle-high level produces nothing.
